// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multicycle RV32I core (R-type add/sub/and/or, lw, sw, beq).
// Define MC_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_source,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal_instr
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, MEM_ADDR, BRANCH, MEM_RD, MEM_WR, WB_R, WB_LD, HALT
    } state_t;

    state_t state, state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_nx  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b10;
                state_nx  = opcode == OP_R                        ? EXEC_R   :
                            (opcode == OP_LW || opcode == OP_SW)  ? MEM_ADDR :
                            (opcode == OP_BR && funct3 == 3'b000) ? BRANCH   : HALT;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_nx  = WB_R;
            end
            WB_R: begin
                reg_write = 1'b1;
                state_nx  = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nx  = opcode == OP_LW ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                i_or_d   = 1'b1;
                state_nx = mem_ready ? WB_LD : MEM_RD;
            end
            WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_nx   = FETCH;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                i_or_d   = 1'b1;
                mem_we   = 1'b1;
                state_nx = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                state_nx      = FETCH;
            end
            HALT: illegal_instr = 1'b1;
            default: state_nx = FETCH;
        endcase
        // State sits at FETCH during reset, so outputs must be forced quiet while rst_n is low.
        if (!rst_n) begin
            alu_op        = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = state == WB_R || state == WB_LD || state == BRANCH ||
                    (state == MEM_WR && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            instret_cnt <= instret_cnt + CNT_W'(retire);
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM outputs per state.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       mem_ready = 1'b1;
    logic [1:0] alu_op, alu_src_b;
    logic       alu_src_a, pc_source, pc_write, pc_write_cond, i_or_d, mem_req, mem_we;
    logic       ir_write, reg_write, mem_to_reg, illegal_instr;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
    logic [1:0]  w_alu_op, w_alu_src_b;
    logic        w_a, w_ps, w_pw, w_pwc, w_iod, w_mr, w_we, w_ir, w_rw, w_m2r, w_ill;
    logic [3:0]  w_cycle, w_instret;

    multicycle_control #(.CNT_W(4)) u_w (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .alu_op(w_alu_op), .alu_src_a(w_a), .alu_src_b(w_alu_src_b), .pc_source(w_ps),
        .pc_write(w_pw), .pc_write_cond(w_pwc), .i_or_d(w_iod), .mem_req(w_mr), .mem_we(w_we),
        .ir_write(w_ir), .reg_write(w_rw), .mem_to_reg(w_m2r), .illegal_instr(w_ill),
        .cycle_cnt(w_cycle), .instret_cnt(w_instret)
    );
`endif

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_req(mem_req),
        .mem_we(mem_we), .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal_instr(illegal_instr)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // {alu_op, src_a, src_b, pc_source, pc_write, pc_write_cond, i_or_d, mem_req, mem_we, ir_write, reg_write, mem_to_reg, illegal}
    logic [14:0] outs;
    assign outs = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, i_or_d,
                   mem_req, mem_we, ir_write, reg_write, mem_to_reg, illegal_instr};

    localparam logic [14:0] E_ZERO  = 15'b00_0_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] E_FET1  = 15'b00_0_01_0_1_0_0_1_0_1_0_0_0;
    localparam logic [14:0] E_FET0  = 15'b00_0_01_0_0_0_0_1_0_0_0_0_0;
    localparam logic [14:0] E_DEC   = 15'b00_0_10_0_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] E_EXR   = 15'b10_1_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] E_WBR   = 15'b00_0_00_0_0_0_0_0_0_0_1_0_0;
    localparam logic [14:0] E_MADDR = 15'b00_1_10_0_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] E_MRD   = 15'b00_0_00_0_0_0_1_1_0_0_0_0_0;
    localparam logic [14:0] E_MWR   = 15'b00_0_00_0_0_0_1_1_1_0_0_0_0;
    localparam logic [14:0] E_WBLD  = 15'b00_0_00_0_0_0_0_0_0_0_1_1_0;
    localparam logic [14:0] E_BR    = 15'b01_1_00_1_0_1_0_0_0_0_0_0_0;
    localparam logic [14:0] E_HALT  = 15'b00_0_00_0_0_0_0_0_0_0_0_0_1;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        tick;
        tick;
        chk("reset_outs", 32'(outs), 32'(E_ZERO));
        rst_n = 1'b1;
        #1 chk("fetch_after_reset", 32'(outs), 32'(E_FET1));
`ifdef MC_PERF_CNT_EN
        chk("cycle_cnt_reset", cycle_cnt, 0);
`endif
        // add x3,x1,x2
        tick; chk("add_decode", 32'(outs), 32'(E_DEC));
        tick; chk("add_exec_r", 32'(outs), 32'(E_EXR));
        tick; chk("add_wb_r", 32'(outs), 32'(E_WBR));
        tick; chk("add_back_fetch", 32'(outs), 32'(E_FET1));
`ifdef MC_PERF_CNT_EN
        chk("instret_after_add", instret_cnt, 1);
        chk("cycle_after_add", cycle_cnt, 4);
`endif
        // lw with two memory wait cycles
        opcode = 7'b0000011;
        tick; chk("lw_decode", 32'(outs), 32'(E_DEC));
        tick; chk("lw_mem_addr", 32'(outs), 32'(E_MADDR));
        mem_ready = 1'b0;
        tick; chk("lw_mem_rd_w1", 32'(outs), 32'(E_MRD));
        tick; chk("lw_mem_rd_w2", 32'(outs), 32'(E_MRD));
        mem_ready = 1'b1;
        #1 chk("lw_mem_rd_go", 32'(outs), 32'(E_MRD));
        tick; chk("lw_wb_ld", 32'(outs), 32'(E_WBLD));
        tick; chk("lw_back_fetch", 32'(outs), 32'(E_FET1));
        // fetch waiting on memory
        mem_ready = 1'b0;
        #1 chk("fetch_wait", 32'(outs), 32'(E_FET0));
        tick; chk("fetch_still_wait", 32'(outs), 32'(E_FET0));
        mem_ready = 1'b1;
        #1 chk("fetch_ready", 32'(outs), 32'(E_FET1));
        // beq
        opcode = 7'b1100011;
        funct3 = 3'b000;
        tick; chk("beq_decode", 32'(outs), 32'(E_DEC));
        tick; chk("beq_branch", 32'(outs), 32'(E_BR));
        tick; chk("beq_back_fetch", 32'(outs), 32'(E_FET1));
`ifdef MC_PERF_CNT_EN
        chk("instret_after_beq", instret_cnt, 3);
`endif
        // sw interrupted by reset while waiting
        opcode = 7'b0100011;
        tick; chk("sw_decode", 32'(outs), 32'(E_DEC));
        tick; chk("sw_mem_addr", 32'(outs), 32'(E_MADDR));
        mem_ready = 1'b0;
        tick; chk("sw_mem_wr_wait", 32'(outs), 32'(E_MWR));
        rst_n = 1'b0;
        #1 chk("sw_reset_mid_req", 32'(outs), 32'(E_ZERO));
`ifdef MC_PERF_CNT_EN
        chk("cycle_cnt_cleared", cycle_cnt, 0);
        chk("instret_cnt_cleared", instret_cnt, 0);
`endif
        tick;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1 chk("fetch_after_sw_reset", 32'(outs), 32'(E_FET1));
        // unsupported opcode halts
        opcode = 7'b0010011;
        tick; chk("halt_decode", 32'(outs), 32'(E_DEC));
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("halt_hold", 32'(outs), 32'(E_HALT));
            mem_ready = ~mem_ready;
            opcode = 7'b0110011;
        end
`ifdef MC_PERF_CNT_EN
        chk("cycle_cnt_in_halt", cycle_cnt, 21);
        chk("instret_in_halt", instret_cnt, 0);
        chk("cycle_cnt_w4_wrap", 32'(w_cycle), 32'(21 % 16));
`endif
        // beq with non-zero funct3 is unsupported too
        rst_n = 1'b0;
        #1 chk("halt_reset_clears", 32'(outs), 32'(E_ZERO));
        tick;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b1100011;
        funct3 = 3'b001;
        tick; chk("bne_decode", 32'(outs), 32'(E_DEC));
        tick; chk("bne_halts", 32'(outs), 32'(E_HALT));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
